// File: rtl/fpu_pkg.sv
// fpu_pkg: rounding-mode codes, fflags bit indices, operand classes and format constants for the FP datapath
package fpu_pkg;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;
  typedef enum logic [2:0] {CL_ZERO, CL_SUB, CL_NORM, CL_INF, CL_QNAN, CL_SNAN} op_class_t;
  function automatic logic [63:0] canon_nan(input int e, input int m);
    return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
  endfunction
  function automatic logic [63:0] max_finite(input int e, input int m);
    return (((64'd1 << e) - 64'd2) << m) | ((64'd1 << m) - 64'd1);
  endfunction
endpackage

// File: rtl/fpu_round.sv
// fpu_round: round-up increment and inexact from sign/lsb/guard/sticky under rm (in: sign lsb guard sticky rm; out: inc inexact)
module fpu_round import fpu_pkg::*; (
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic [2:0] rm,
  output logic       inc,
  output logic       inexact
);
  always_comb begin
    inexact = guard | sticky;
    inc = rm == RM_RTZ ? 1'b0 :
          rm == RM_RDN ? sign & inexact :
          rm == RM_RUP ? !sign & inexact :
          rm == RM_RMM ? guard :
          guard & (sticky | lsb);
  end
endmodule

// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: 3-stage IEEE-754 multiplier with valid/ready (in: CLK RST En Rs1 Rs2 rm out_ready; out: in_ready out_valid Result fflags overflow)
module fpu_mul_pipe import fpu_pkg::*; #(
  parameter int FLEN     = 32,
  parameter int EXP      = 8,
  parameter int MANTISSA = 23
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            En,
  output logic            in_ready,
  input  logic [FLEN-1:0] Rs1,
  input  logic [FLEN-1:0] Rs2,
  input  logic [2:0]      rm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] Result,
  output logic [4:0]      fflags,
  output logic            overflow
);
  localparam int M = MANTISSA;
  localparam int PW = 2 * M + 2;
  localparam int EW = EXP + 2;
  localparam logic [63:0] NAN64 = canon_nan(EXP, M);
  localparam logic [63:0] MAX64 = max_finite(EXP, M);
  localparam logic [FLEN-1:0] QNAN = NAN64[FLEN-1:0];
  localparam logic [FLEN-2:0] MAXF = MAX64[FLEN-2:0];
  localparam logic [EW-1:0] BIAS = EW'(2 ** (EXP - 1) - 1);
  localparam logic [EW-1:0] EMAX = EW'(2 ** EXP - 1);
  typedef struct packed {
    logic            sign;
    logic [EW-1:0]   ex;
    logic [M:0]      ma;
    logic [M:0]      mb;
    logic [2:0]      rm;
    logic            spec;
    logic [FLEN-1:0] spec_res;
    logic [4:0]      spec_flags;
  } s1_t;
  typedef struct packed {
    logic            sign;
    logic [EW-1:0]   ex;
    logic [PW-1:0]   prod;
    logic [2:0]      rm;
    logic            spec;
    logic [FLEN-1:0] spec_res;
    logic [4:0]      spec_flags;
  } s2_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, adv1, adv2, adv3;
  op_class_t ca, cb;
  logic snan, nan, inf, zero, nv;
  logic [PW-2:0] pn;
  logic [EW-1:0] e_n, e_r;
  logic [M-1:0] mant;
  logic [M:0] mant_r;
  logic guard, sticky, inc, inexact, ovf, unf, to_inf;
  logic [FLEN-1:0] res3, result_d, result_q;
  logic [4:0] flg3, fflags_d, fflags_q;
  function automatic op_class_t classify(input logic [FLEN-2:0] x);
    return x[FLEN-2:M] == '0 ? (x[M-1:0] == '0 ? CL_ZERO : CL_SUB) :
           &x[FLEN-2:M] ? (x[M-1:0] == '0 ? CL_INF : x[M-1] ? CL_QNAN : CL_SNAN) : CL_NORM;
  endfunction
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
    v1_d = adv1 ? En : v1_q;
    v2_d = adv2 ? v1_q : v2_q;
    v3_d = adv3 ? v2_q : v3_q;
  end
  always_comb begin
    ca = classify(Rs1[FLEN-2:0]);
    cb = classify(Rs2[FLEN-2:0]);
    snan = ca == CL_SNAN || cb == CL_SNAN;
    nan = snan || ca == CL_QNAN || cb == CL_QNAN;
    inf = ca == CL_INF || cb == CL_INF;
    zero = ca == CL_ZERO || ca == CL_SUB || cb == CL_ZERO || cb == CL_SUB;
    nv = snan || (inf && zero);
    s1_d.sign = Rs1[FLEN-1] ^ Rs2[FLEN-1];
    s1_d.ex = {2'b00, Rs1[FLEN-2:M]} + {2'b00, Rs2[FLEN-2:M]} - BIAS;
    s1_d.ma = {1'b1, Rs1[M-1:0]};
    s1_d.mb = {1'b1, Rs2[M-1:0]};
    s1_d.rm = rm > RM_RMM ? RM_RNE : rm;
    s1_d.spec = nan || inf || zero;
    s1_d.spec_res = nan || nv ? QNAN : {s1_d.sign, {EXP{inf}}, {M{1'b0}}};
    s1_d.spec_flags = '0;
    s1_d.spec_flags[FF_NV] = nv;
  end
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.ex = s1_q.ex;
    s2_d.prod = PW'(s1_q.ma) * PW'(s1_q.mb);
    s2_d.rm = s1_q.rm;
    s2_d.spec = s1_q.spec;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.spec_flags = s1_q.spec_flags;
  end
  fpu_round u_round (
    .sign    (s2_q.sign),
    .lsb     (mant[0]),
    .guard   (guard),
    .sticky  (sticky),
    .rm      (s2_q.rm),
    .inc     (inc),
    .inexact (inexact)
  );
  always_comb begin
    pn = s2_q.prod[PW-1] ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
    e_n = s2_q.ex + EW'(s2_q.prod[PW-1]);
    mant = pn[PW-2 -: M];
    guard = pn[PW-2-M];
    sticky = |pn[PW-3-M:0];
    mant_r = {1'b0, mant} + (M+1)'(inc);
    e_r = e_n + EW'(mant_r[M]);
    ovf = $signed(e_r) >= $signed(EMAX);
    unf = !ovf && (e_r[EW-1] || e_r == '0);
    to_inf = s2_q.rm == RM_RNE || s2_q.rm == RM_RMM || (s2_q.rm == RM_RUP && !s2_q.sign) || (s2_q.rm == RM_RDN && s2_q.sign);
    res3 = s2_q.spec ? s2_q.spec_res :
           ovf ? {s2_q.sign, to_inf ? {{EXP{1'b1}}, {M{1'b0}}} : MAXF} :
           unf ? {s2_q.sign, {(FLEN-1){1'b0}}} :
           {s2_q.sign, e_r[EXP-1:0], mant_r[M-1:0]};
    flg3 = '0;
    flg3[FF_DZ] = 1'b0;
    flg3[FF_OF] = ovf;
    flg3[FF_UF] = unf;
    flg3[FF_NX] = inexact || ovf || unf;
    flg3 = s2_q.spec ? s2_q.spec_flags : flg3;
    result_d = adv3 && v2_q ? res3 : result_q;
    fflags_d = adv3 && v2_q ? flg3 : fflags_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (adv1) s1_q <= s1_d;
    if (adv2) s2_q <= s2_d;
  end
  assign in_ready = adv1;
  assign out_valid = v3_q;
  assign Result = result_q;
  assign fflags = fflags_q;
  assign overflow = fflags_q[FF_OF];
endmodule
